game_flow_ctrl: RTL and testbench

- Top-level game-flow state machine, directly upstream of the screen-drawing stage.
- Turns raw keyboard levels and gameplay events into the control signals that stage consumes:
  - a one-cycle start_game pulse
  - lose/win levels that select the overlay screens
  - a game_run enable for the player/physics logic
- Handles key edge detection, a frame-based key-lockout timer, auto-return to the start screen and the tower level counter.

---
 rtl/game_flow_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Top-level game-flow state machine that sits directly upstream of the
// screen-drawing stage. It turns raw keyboard levels and gameplay events into
// the control signals that stage consumes:
//   - a one-cycle start_game pulse
//   - lose / win levels that select the overlay screens
//   - a game_run enable for the player/physics logic
// It also handles key edge detection, a frame-based key lockout on the result
// screens, auto-return to the start screen and the tower level counter.
//
// Optional feature macro: GAME_FLOW_PAUSE_EN
//   Adds the key_p input and a PAUSE state (screen_sel=01 with game_run=0).
//
// Ports
//   clk           in   system/pixel clock
//   rst           in   asynchronous, active-low reset
//   key_enter     in   Enter key level
//   key_space     in   Space key level
//   key_p         in   P key level (GAME_FLOW_PAUSE_EN only)
//   frame_tick    in   one-cycle pulse per frame
//   player_dead   in   a player touched a lethal pool
//   exit_reached  in   both players at their doors
//   start_game    out  one-cycle pulse on entry to PLAY from START/LOSE/WIN
//   game_run      out  high while in PLAY
//   lose          out  high while in LOSE
//   win           out  high while in WIN
//   screen_sel    out  00 START, 01 PLAY/PAUSE, 10 LOSE, 11 WIN
//   level         out  current tower level
//
// States
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_START | title screen, waiting for a key press
//   ST_PLAY  | gameplay running
//   ST_LOSE  | lose overlay, keys locked for LOCK_FRAMES, auto-return
//   ST_WIN   | win overlay, keys locked for LOCK_FRAMES, auto-return
//   ST_PAUSE | gameplay frozen (GAME_FLOW_PAUSE_EN only)
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int unsigned LOCK_FRAMES   = 30,
    parameter int unsigned RESULT_FRAMES = 300,
    parameter int unsigned MAX_LEVEL     = 8,
    parameter int unsigned LVL_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_enter,
    input  logic             key_space,
`ifdef GAME_FLOW_PAUSE_EN
    input  logic             key_p,
`endif
    input  logic             frame_tick,
    input  logic             player_dead,
    input  logic             exit_reached,
    output logic             start_game,
    output logic             game_run,
    output logic             lose,
    output logic             win,
    output logic [1:0]       screen_sel,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned        TMR_W      = $clog2(RESULT_FRAMES + 1);
    localparam logic [TMR_W-1:0]   LOCK_VAL   = TMR_W'(LOCK_FRAMES);
    localparam logic [TMR_W-1:0]   RESULT_VAL = TMR_W'(RESULT_FRAMES);
    localparam logic [LVL_W-1:0]   LEVEL_LAST = LVL_W'(MAX_LEVEL - 1);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_LOSE  = 3'd2,
        ST_WIN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               key_prev_q;
    logic               start_q, start_d;
    logic               run_q, lose_q, win_q;
    logic [1:0]         sel_q, sel_d;
    logic               key_any;
    logic               go;
    logic               locked;
    logic               pause_go;

`ifdef GAME_FLOW_PAUSE_EN
    logic               key_p_prev_q;
    assign pause_go = key_p & ~key_p_prev_q;
`else
    assign pause_go = 1'b0;
`endif

    // Edge registers reset to 1 so a key held through reset is not a press.
    assign key_any = key_enter | key_space;
    assign go      = key_any & ~key_prev_q;
    assign locked  = (timer_q < LOCK_VAL);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        start_d = 1'b0;
        case (state_q)
            ST_START: begin
                if (go) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Death outranks reaching the exit in the same cycle.
                if (player_dead) begin
                    state_d = ST_LOSE;
                end else if (exit_reached) begin
                    state_d = ST_WIN;
                    level_d = (level_q >= LEVEL_LAST) ? '0 : level_q + 1'b1;
                end else if (pause_go) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_LOSE, ST_WIN: begin
                // A key press beats the auto-return when both land together.
                if (go && !locked) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end else if (timer_q == RESULT_VAL) begin
                    state_d = ST_START;
                    if (state_q == ST_LOSE) begin
                        level_d = '0;
                    end
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSE: begin
                if (pause_go || go) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: begin
                state_d = ST_START;
            end
        endcase

        // Timer restarts on every state change and only runs on result screens.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == ST_LOSE || state_q == ST_WIN) &&
                     frame_tick && (timer_q != RESULT_VAL)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        case (state_d)
            ST_PLAY, ST_PAUSE: sel_d = 2'b01;
            ST_LOSE:           sel_d = 2'b10;
            ST_WIN:            sel_d = 2'b11;
            default:           sel_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_START;
            timer_q    <= '0;
            level_q    <= '0;
            key_prev_q <= 1'b1;
`ifdef GAME_FLOW_PAUSE_EN
            key_p_prev_q <= 1'b1;
`endif
            start_q    <= 1'b0;
            run_q      <= 1'b0;
            lose_q     <= 1'b0;
            win_q      <= 1'b0;
            sel_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            level_q    <= level_d;
            key_prev_q <= key_any;
`ifdef GAME_FLOW_PAUSE_EN
            key_p_prev_q <= key_p;
`endif
            start_q    <= start_d;
            run_q      <= (state_d == ST_PLAY);
            lose_q     <= (state_d == ST_LOSE);
            win_q      <= (state_d == ST_WIN);
            sel_q      <= sel_d;
        end
    end

    assign start_game = start_q;
    assign game_run   = run_q;
    assign lose       = lose_q;
    assign win        = win_q;
    assign screen_sel = sel_q;
    assign level      = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for game_flow_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the game flow.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

    localparam int LOCK = 30;
    localparam int RES  = 300;
    localparam int MAXL = 8;
    localparam int LW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_enter = 1'b0;
    logic key_space = 1'b0;
    logic frame_tick = 1'b0;
    logic player_dead = 1'b0;
    logic exit_reached = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
    logic key_p = 1'b0;
`endif
    logic          start_game;
    logic          game_run;
    logic          lose;
    logic          win;
    logic [1:0]    screen_sel;
    logic [LW-1:0] level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .LOCK_FRAMES  (LOCK),
        .RESULT_FRAMES(RES),
        .MAX_LEVEL    (MAXL),
        .LVL_W        (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_enter   (key_enter),
        .key_space   (key_space),
`ifdef GAME_FLOW_PAUSE_EN
        .key_p       (key_p),
`endif
        .frame_tick  (frame_tick),
        .player_dead (player_dead),
        .exit_reached(exit_reached),
        .start_game  (start_game),
        .game_run    (game_run),
        .lose        (lose),
        .win         (win),
        .screen_sel  (screen_sel),
        .level       (level)
    );

    // Model: which screen we are on, frames seen on a result screen, level.
    localparam int M_START = 0;
    localparam int M_PLAY  = 1;
    localparam int M_LOSE  = 2;
    localparam int M_WIN   = 3;
    localparam int M_PAUSE = 4;

    int m_state;
    int m_frames;
    int m_level;
    bit m_prev;
    bit m_prev_p;
    bit m_pulse;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = M_START;
        m_frames = 0;
        m_level  = 0;
        m_prev   = 1'b1;
        m_prev_p = 1'b1;
        m_pulse  = 1'b0;
    endtask

    task automatic enter(input int s);
        m_state  = s;
        m_frames = 0;
    endtask

    task automatic model_step();
        bit k;
        bit go;
        bit pgo;
        if (!rst) begin
            model_reset();
            return;
        end
        k = key_enter | key_space;
        go = k && !m_prev;
        m_prev = k;
        pgo = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
        pgo = key_p && !m_prev_p;
        m_prev_p = key_p;
`endif
        m_pulse = 1'b0;
        case (m_state)
            M_START: begin
                if (go) begin
                    enter(M_PLAY);
                    m_pulse = 1'b1;
                end
            end
            M_PLAY: begin
                if (player_dead) enter(M_LOSE);
                else if (exit_reached) begin
                    enter(M_WIN);
                    m_level = (m_level + 1) % MAXL;
                end else if (pgo) enter(M_PAUSE);
            end
            M_PAUSE: begin
                if (pgo || go) enter(M_PLAY);
            end
            default: begin
                if (go && m_frames >= LOCK) begin
                    enter(M_PLAY);
                    m_pulse = 1'b1;
                end else if (m_frames == RES) begin
                    if (m_state == M_LOSE) m_level = 0;
                    enter(M_START);
                end else if (frame_tick) begin
                    m_frames++;
                end
            end
        endcase
    endtask

    task automatic compare();
        int sel;
        sel = (m_state == M_PAUSE) ? 1 : m_state;
        chk("start_game", start_game, m_pulse);
        chk("game_run", game_run, m_state == M_PLAY);
        chk("lose", lose, m_state == M_LOSE);
        chk("win", win, m_state == M_WIN);
        chk("screen_sel", screen_sel, sel);
        chk("level", level, m_level);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic press();
        key_space = 1'b1;
        step();
        key_space = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic win_once();
        exit_reached = 1'b1;
        step();
        exit_reached = 1'b0;
        ticks(LOCK);
        press();
    endtask

    int pulses;

    initial begin
        model_reset();
        #2;
        chk("reset_screen", screen_sel, 0);
        chk("reset_level", level, 0);
        chk("reset_start", start_game, 0);
        chk("reset_run", game_run, 0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // Enter held for 100 cycles: one pulse, the cycle after the edge.
        key_enter = 1'b1;
        step();
        chk("first_pulse", start_game, 1);
        chk("first_run", game_run, 1);
        chk("first_sel", screen_sel, 1);
        pulses = 1;
        repeat (99) begin
            step();
            if (start_game) pulses++;
        end
        chk("held_pulses", pulses, 1);
        key_enter = 1'b0;
        step();

        // Death and exit together: lose wins.
        player_dead = 1'b1;
        exit_reached = 1'b1;
        step();
        player_dead = 1'b0;
        exit_reached = 1'b0;
        chk("both_lose", lose, 1);
        chk("both_win", win, 0);
        chk("both_sel", screen_sel, 2);
        chk("both_level", level, 0);

        // Press while locked is ignored, press after lockout retries.
        ticks(10);
        key_space = 1'b1;
        step();
        chk("locked_lose", lose, 1);
        chk("locked_pulse", start_game, 0);
        key_space = 1'b0;
        step();
        ticks(21);
        key_space = 1'b1;
        step();
        chk("retry_pulse", start_game, 1);
        chk("retry_run", game_run, 1);
        chk("retry_level", level, 0);
        key_space = 1'b0;
        step();

        // Climb to level 7, win once more: wrap to 0, auto-return keeps 0.
        repeat (7) win_once();
        chk("climb_level", level, 7);
        exit_reached = 1'b1;
        step();
        exit_reached = 1'b0;
        chk("wrap_win", win, 1);
        chk("wrap_level", level, 0);
        ticks(RES);
        step();
        chk("wrap_auto_sel", screen_sel, 0);
        chk("wrap_auto_level", level, 0);

        // From level 2 a win shows level 3, which START keeps.
        press();
        repeat (2) win_once();
        exit_reached = 1'b1;
        step();
        exit_reached = 1'b0;
        ticks(RES);
        step();
        chk("keep_sel", screen_sel, 0);
        chk("keep_level", level, 3);

        // Lose auto-return resets the level.
        press();
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        ticks(RES);
        step();
        chk("lose_auto_sel", screen_sel, 0);
        chk("lose_auto_level", level, 0);

        // Go on the same cycle as the last frame tick: play wins.
        press();
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        ticks(RES - 1);
        frame_tick = 1'b1;
        key_space = 1'b1;
        step();
        chk("race_run", game_run, 1);
        chk("race_pulse", start_game, 1);
        frame_tick = 1'b0;
        key_space = 1'b0;
        step();

        // Asynchronous reset mid-play at level 5, key held through it.
        repeat (5) win_once();
        chk("pre_rst_level", level, 5);
        chk("pre_rst_run", game_run, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_run", game_run, 0);
        chk("arst_level", level, 0);
        chk("arst_sel", screen_sel, 0);
        chk("arst_pulse", start_game, 0);
        model_reset();
        key_enter = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        chk("held_rst_pulse", start_game, 0);
        key_enter = 1'b0;
        step();

`ifdef GAME_FLOW_PAUSE_EN
        press();
        key_p = 1'b1;
        step();
        chk("pause_run", game_run, 0);
        chk("pause_sel", screen_sel, 1);
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        chk("pause_dead", lose, 0);
        key_p = 1'b0;
        step();
        key_p = 1'b1;
        step();
        chk("resume_run", game_run, 1);
        chk("resume_pulse", start_game, 0);
        key_p = 1'b0;
        step();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) key_enter = ~key_enter;
            if ($urandom_range(0, 15) == 0) key_space = ~key_space;
`ifdef GAME_FLOW_PAUSE_EN
            if ($urandom_range(0, 19) == 0) key_p = ~key_p;
`endif
            frame_tick   = $urandom_range(0, 1);
            player_dead  = ($urandom_range(0, 59) == 0);
            exit_reached = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
